apb_slave_mem: RTL

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem.sv | 118 +++++++++++
 1 files changed

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB slave backed by a small word memory with programmable wait states.
module apb_slave_mem #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] LIMIT     = 32'(DEPTH * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state_q;
    state_t        state;
    state_t        state_d;
    logic [3:0]    cnt_q;
    logic [AW-1:0] idx_q;
    logic          err_q;
    logic          wr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem [DEPTH];

    logic          bus_err;
    logic [AW-1:0] bus_idx;
    logic          rd_load;
    logic          rd_err;
    logic [AW-1:0] rd_idx;

    assign bus_err = (PADDR[1:0] != 2'b00) || (PADDR >= LIMIT);
    assign bus_idx = PADDR[AW+1:2];

    // The setup phase is recognised in the cycle the bridge presents it, so the
    // first access cycle already runs against the latched request.
    always_comb begin
        state   = state_q;
        state_d = IDLE;
        PREADY  = 1'b0;
        if (state_q == IDLE && PSEL && !PENABLE) begin
            state = SETUP;
        end
        case (state)
            IDLE:    state_d = IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (!(PSEL && PENABLE)) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    PREADY  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                end
            end
            default: state_d = IDLE;
        endcase
        PSLVERR = PREADY && err_q;
    end

    // Read data is fetched on the edge that opens the completion cycle.
    always_comb begin
        rd_load = 1'b0;
        rd_idx  = idx_q;
        rd_err  = err_q;
        if (state == SETUP) begin
            rd_idx  = bus_idx;
            rd_err  = bus_err;
            rd_load = !PWRITE && (WAIT_INIT == 4'd0);
        end else if (state == ACCESS) begin
            rd_load = !wr_q && PSEL && PENABLE && (cnt_q == 4'd1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= 32'd0;
            PRDATA  <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            if (state == SETUP) begin
                idx_q   <= bus_idx;
                err_q   <= bus_err;
                wr_q    <= PWRITE;
                wdata_q <= PWDATA;
                cnt_q   <= WAIT_INIT;
            end else if (state == ACCESS && PSEL && PENABLE && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end else begin
                cnt_q <= 4'd0;
            end
            if (rd_load) begin
                PRDATA <= rd_err ? 32'd0 : mem[rd_idx];
            end
            if (PREADY && wr_q && !err_q) begin
                mem[idx_q] <= wdata_q;
            end
        end
    end

endmodule
